// File: rtl/player_2_ctl.sv
// Player 2 movement/animation controller: steps position, jump arc and walk
// animation once per frame on the rising edge of vertical blanking.
package state_pkg;
    typedef enum logic [2:0] {IDLE, LEFT1, LEFT2, RIGHT1, RIGHT2} State;
endpackage

module player_2_ctl
    import state_pkg::*;
#(
    parameter logic [11:0] X_START     = 12'd100,
    parameter logic [11:0] X_MAX       = 12'd760,
    parameter logic [11:0] STEP        = 12'd4,
    parameter logic [11:0] GROUND_Y    = 12'd60,
    parameter logic [11:0] JUMP_H      = 12'd60,
    parameter logic [11:0] JUMP_STEP   = 12'd4,
    parameter logic [7:0]  ANIM_FRAMES = 8'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        left,
    input  logic        right,
    input  logic        jump,
    output logic [11:0] xpos_player2,
    output logic [11:0] ypos_player2,
    output State        state
);

    typedef enum logic [1:0] {DIR_NONE, DIR_L, DIR_R} dir_t;
    typedef enum logic [1:0] {GROUND, RISE, FALL} jump_t;

    logic        r_vblnk_d;
    logic [11:0] r_x;
    logic [11:0] r_y;
    jump_t       r_jst;
    logic        r_phase;
    logic [7:0]  r_anim_cnt;
    dir_t        r_dir_prev;
    State        r_state;

    logic        w_tick;
    dir_t        w_dir;
    logic [11:0] w_apex;
    logic [12:0] w_x_inc;
    logic [12:0] w_y_inc;
    logic [12:0] w_y_floor;
    logic [11:0] w_y_rise;
    logic [11:0] w_x_nxt;
    logic [11:0] w_y_nxt;
    jump_t       w_jst_nxt;
    logic        w_phase_nxt;
    logic [7:0]  w_anim_nxt;
    State        w_state_nxt;

    // One tick per frame regardless of how long vblnk stays high.
    assign w_tick    = vblnk & ~r_vblnk_d;
    assign w_apex    = GROUND_Y - JUMP_H;
    assign w_x_inc   = {1'b0, r_x} + {1'b0, STEP};
    assign w_y_inc   = {1'b0, r_y} + {1'b0, JUMP_STEP};
    assign w_y_floor = {1'b0, w_apex} + {1'b0, JUMP_STEP};
    assign w_y_rise  = ({1'b0, r_y} < w_y_floor) ? w_apex : (r_y - JUMP_STEP);

    always_comb begin
        w_dir = DIR_NONE;
        if (right && !left)
            w_dir = DIR_R;
        else if (left && !right)
            w_dir = DIR_L;
    end

    always_comb begin
        w_x_nxt = r_x;
        case (w_dir)
            DIR_R:   w_x_nxt = (w_x_inc > {1'b0, X_MAX}) ? X_MAX : w_x_inc[11:0];
            DIR_L:   w_x_nxt = (r_x < STEP) ? 12'd0 : (r_x - STEP);
            default: w_x_nxt = r_x;
        endcase
    end

    // Jump arc: GROUND -> RISE until apex -> FALL until ground.
    always_comb begin
        w_jst_nxt = r_jst;
        w_y_nxt   = r_y;
        case (r_jst)
            GROUND: begin
                if (jump) begin
                    w_jst_nxt = RISE;
                    w_y_nxt   = w_y_rise;
                end
            end
            RISE: begin
                w_y_nxt = w_y_rise;
                if (w_y_rise == w_apex)
                    w_jst_nxt = FALL;
            end
            FALL: begin
                if (w_y_inc >= {1'b0, GROUND_Y}) begin
                    w_y_nxt   = GROUND_Y;
                    w_jst_nxt = GROUND;
                end else begin
                    w_y_nxt = w_y_inc[11:0];
                end
            end
            default: begin
                w_jst_nxt = GROUND;
                w_y_nxt   = GROUND_Y;
            end
        endcase
    end

    always_comb begin
        w_phase_nxt = 1'b0;
        w_anim_nxt  = 8'd0;
        if (w_dir != DIR_NONE && w_dir == r_dir_prev) begin
            if (r_anim_cnt == ANIM_FRAMES - 8'd1) begin
                w_anim_nxt  = 8'd0;
                w_phase_nxt = ~r_phase;
            end else begin
                w_anim_nxt  = r_anim_cnt + 8'd1;
                w_phase_nxt = r_phase;
            end
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        case (w_dir)
            DIR_R:   w_state_nxt = w_phase_nxt ? RIGHT2 : RIGHT1;
            DIR_L:   w_state_nxt = w_phase_nxt ? LEFT2 : LEFT1;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vblnk_d  <= 1'b0;
            r_x        <= X_START;
            r_y        <= GROUND_Y;
            r_jst      <= GROUND;
            r_phase    <= 1'b0;
            r_anim_cnt <= 8'd0;
            r_dir_prev <= DIR_NONE;
            r_state    <= IDLE;
        end else begin
            r_vblnk_d <= vblnk;
            if (w_tick) begin
                r_x        <= w_x_nxt;
                r_y        <= w_y_nxt;
                r_jst      <= w_jst_nxt;
                r_phase    <= w_phase_nxt;
                r_anim_cnt <= w_anim_nxt;
                r_dir_prev <= w_dir;
                r_state    <= w_state_nxt;
            end
        end
    end

    assign xpos_player2 = r_x;
    assign ypos_player2 = r_y;
    assign state        = r_state;

endmodule
